learn_sequencer: RTL and testbench
==================================

# learn_sequencer

Parametrised learning-mode sequencer for the piano trainer. It walks a stored song note by note and drives the expected note/pitch onto the LEDs. It advances when the player holds the matching key for the stored duration. It supports multiple songs, a release-before-next-note rule, optional timed mode with miss counting, and hit/miss scoring. It sits between the keyboard decoder (`key_in`) and the shared song ROM, in parallel with the buzzer path.

## Interface
- `NOTE_W`, 10: note+pitch word; upper `NOTE_W-3` bits are the note field, low 3 bits are pitch.
- `ADDR_W`, 7: ROM address width per song. Word 0 of each song holds the note count.
- `DUR_W`, 32: duration word width, in clk cycles.
- `SONG_W`, 2: song select width (up to 4 songs).
- `TIMEOUT`, 100_000_000: timed-mode window per note, in cycles. Must be ≥1.
- `clk` in 1: system clock.
- `rst_n` in 1: reset; asynchronous, active-low.
- `start` in 1: single-cycle pulse that starts or restarts a song. Accepted only in IDLE or DONE.
- `song_sel` in SONG_W: song index, sampled on an accepted `start`.
- `timed` in 1: mode select, sampled on an accepted `start`. 0 = wait mode, 1 = timed mode.
- `key_in` in NOTE_W: current player key, note field plus pitch.
- `rom_song` out SONG_W: ROM song select.
- `rom_addr` out ADDR_W: ROM word address.
- `rom_note` in NOTE_W: ROM note data, valid 1 cycle after the address.
- `rom_dur` in DUR_W: ROM duration data, valid 1 cycle after the address.
- `led` out NOTE_W: expected note. 0 when not PLAY.
- `busy` out 1: high in every state except IDLE and DONE.
- `done` out 1: high in DONE.
- `note_idx` out ADDR_W: current note index, 1-based.
- `hit_count` out ADDR_W: notes played correctly.
- `miss_count` out ADDR_W: notes timed out.

## Operation
- States:
  - IDLE → LEN on accepted `start`. Latch `song_sel`/`timed`, set `rom_addr`=0, clear counters.
  - LEN: one wait cycle.
  - LENCAP: capture `len`=rom_note[ADDR_W-1:0]. If `len`==0 → DONE; else `note_idx`=1, `rom_addr`=1 → FETCH.
  - FETCH: one wait cycle.
  - LOAD: register `exp_note`/`exp_dur`, clear `hold_cnt` and `wait_cnt` → PLAY.
  - PLAY: scoring.
  - ADV: if `note_idx`==`len` → DONE; else increment `note_idx`, `rom_addr`=`note_idx`+1 → FETCH.
  - DONE: hold until the next `start` (→ LEN) or reset.
- PLAY, match: `armed` && `key_in`==`exp_note` increments `hold_cnt`. Any mismatch clears `hold_cnt` to 0.
- PLAY, hit: `hold_cnt`==`exp_dur` while matching. Increment `hit_count`, clear `armed`, → ADV. Requires `exp_dur`+1 consecutive matching cycles; `exp_dur`=0 gives a hit on the first matching cycle.
- Release rule: `armed` sets on any cycle where `key_in[NOTE_W-1:3]`==0, in any state. It is set on song start, so the first note needs no release. It prevents one long press from scoring repeated identical notes.
- Timed mode:
  - `wait_cnt` increments each PLAY cycle.
  - `wait_cnt`==TIMEOUT-1 without a hit gives a miss: increment `miss_count`, → ADV.
  - If a hit and a timeout occur in the same cycle, the hit wins and there is no miss.
- Wait mode: no timeout; `wait_cnt` is held at 0.
- Counters cannot overflow: `hit_count`+`miss_count` ≤ `len` ≤ 2^ADDR_W-1.
- `start` while `busy` is ignored.
- Reset mid-song: return to IDLE immediately and zero all outputs and counters.

## Timing
- Reset values: `led`=0, `busy`=0, `done`=0, `note_idx`=0, `hit_count`=0, `miss_count`=0, `rom_addr`=0, `rom_song`=0. Internal `armed`=1.
- `start` → `busy` high next cycle. `start` → first `led` valid 5 cycles later (LEN, LENCAP, FETCH, LOAD, then PLAY).
- Hit → next `led` valid 4 cycles later (ADV, FETCH, LOAD, PLAY). `led`=0 during the gap.
- Last hit/miss → `done` high 2 cycles later (ADV, DONE).
- All outputs are registered. ROM read latency is fixed at 1 cycle.

## Configuration
- `LEARN_TIMED_EN` defined: timed mode, `wait_cnt`, and `miss_count` are built as described above.
- `LEARN_TIMED_EN` undefined:
  - `timed` input is ignored; behaviour is always wait mode.
  - `miss_count` is tied to 0.
  - No timeout counter logic is built.

## Structure
- `learn_pkg`:
  - state enum `learn_state_t` (IDLE, LEN, LENCAP, FETCH, LOAD, PLAY, ADV, DONE);
  - localparam `PITCH_W`=3;
  - function `note_field(key)`, which returns `key[NOTE_W-1:PITCH_W]`.
- One sub-module, `learn_hold_timer`:
  - inputs: `clr`, `match`, `dur`;
  - owns `hold_cnt`;
  - outputs a `hit` pulse;
  - clears on mismatch.

## Test plan
- Song 0, len=2, notes 0x048/0x088, dur=3, wait mode. Hold each key 4 cycles, release between notes → `hit_count`=2, `done`=1, `led`=0.
- Same song, key 0x048 held 3 cycles, released 1 cycle, then held 4 → only one hit, registered at the end of the second press.
- Consecutive identical notes 0x048, 0x048. Key held continuously → second note not scored until `key_in` note field reads 0, then a 4-cycle press.
- Timed mode, TIMEOUT=10, no key pressed → miss at PLAY cycle 10. `miss_count` increments per note; `done` after len×(10+4)+… cycles.
- Timed mode, hit completes exactly on cycle TIMEOUT-1 → `hit_count`+1, `miss_count` unchanged.
- `rst_n` asserted mid-PLAY on note 2 → next edge `busy`=0, `led`=0, counters 0. `start` with `song_sel`=1 fetches address 0 of song 1 and `len`=0 gives `done` in 3 cycles.

Source files
------------

// File: rtl/learn_pkg.sv
// Shared types and helpers for the learning-mode sequencer.
package learn_pkg;

  localparam int unsigned PITCH_W = 3;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    LENCAP,
    FETCH,
    LOAD,
    PLAY,
    ADV,
    DONE
  } learn_state_t;

  // Callers pass the key zero-extended to 32 bits; the result is the note field.
  function automatic logic [31:0] note_field(input logic [31:0] key);
    return key >> PITCH_W;
  endfunction

endpackage

// File: rtl/learn_hold_timer.sv
// Counts consecutive matching cycles and pulses hit once the stored duration is reached.
module learn_hold_timer
  import learn_pkg::*;
#(
  parameter int unsigned DUR_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             match,
  input  logic [DUR_W-1:0] dur,
  output logic             hit
);

  logic [DUR_W-1:0] hold_cnt_q, hold_cnt_d;

  assign hit = match && (hold_cnt_q == dur);

  always_comb begin
    hold_cnt_d = hold_cnt_q;
    if (clr || !match || hit) begin
      hold_cnt_d = '0;
    end else begin
      hold_cnt_d = hold_cnt_q + DUR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt_q <= '0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
    end
  end

endmodule

// File: rtl/learn_sequencer.sv
// Learning-mode sequencer: walks a song from ROM and scores the player's key presses.
// Timed mode with miss counting is built only when LEARN_TIMED_EN is defined.
module learn_sequencer
  import learn_pkg::*;
#(
  parameter int unsigned NOTE_W  = 10,
  parameter int unsigned ADDR_W  = 7,
  parameter int unsigned DUR_W   = 32,
  parameter int unsigned SONG_W  = 2,
  parameter int unsigned TIMEOUT = 100_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [SONG_W-1:0] song_sel,
  input  logic              timed,
  input  logic [NOTE_W-1:0] key_in,
  output logic [SONG_W-1:0] rom_song,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [NOTE_W-1:0] rom_note,
  input  logic [DUR_W-1:0]  rom_dur,
  output logic [NOTE_W-1:0] led,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] note_idx,
  output logic [ADDR_W-1:0] hit_count,
  output logic [ADDR_W-1:0] miss_count
);

  learn_state_t      state_q, state_d;
  logic [SONG_W-1:0] rom_song_q, rom_song_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [ADDR_W-1:0] note_idx_q, note_idx_d;
  logic [ADDR_W-1:0] hit_count_q, hit_count_d;
  logic [NOTE_W-1:0] exp_note_q, exp_note_d;
  logic [DUR_W-1:0]  exp_dur_q, exp_dur_d;
  logic [NOTE_W-1:0] led_q, led_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              armed_q, armed_d;
  logic              start_ok;
  logic              match;
  logic              hit;
  logic              timeout;

  assign start_ok = start && ((state_q == IDLE) || (state_q == DONE));
  assign match    = (state_q == PLAY) && armed_q && (key_in == exp_note_q);

  learn_hold_timer #(
    .DUR_W(DUR_W)
  ) u_hold (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (state_q != PLAY),
    .match(match),
    .dur  (exp_dur_q),
    .hit  (hit)
  );

`ifdef LEARN_TIMED_EN
  localparam int unsigned WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  logic              timed_q, timed_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [ADDR_W-1:0] miss_count_q, miss_count_d;

  assign timeout = timed_q && (state_q == PLAY) && (wait_cnt_q == WAIT_LAST);

  always_comb begin
    timed_d      = timed_q;
    wait_cnt_d   = wait_cnt_q;
    miss_count_d = miss_count_q;
    if (start_ok) begin
      timed_d      = timed;
      miss_count_d = '0;
    end
    if (!timed_q || (state_q != PLAY)) begin
      wait_cnt_d = '0;
    end else begin
      wait_cnt_d = wait_cnt_q + WAIT_W'(1);
    end
    // A hit landing on the final window cycle takes precedence over the miss.
    if (timeout && !hit) begin
      miss_count_d = miss_count_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timed_q      <= 1'b0;
      wait_cnt_q   <= '0;
      miss_count_q <= '0;
    end else begin
      timed_q      <= timed_d;
      wait_cnt_q   <= wait_cnt_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign miss_count = miss_count_q;
`else
  logic unused_cfg;
  assign unused_cfg = timed | (TIMEOUT == 0);
  assign timeout    = 1'b0;
  assign miss_count = '0;
`endif

  always_comb begin
    state_d     = state_q;
    rom_song_d  = rom_song_q;
    rom_addr_d  = rom_addr_q;
    len_d       = len_q;
    note_idx_d  = note_idx_q;
    hit_count_d = hit_count_q;
    exp_note_d  = exp_note_q;
    exp_dur_d   = exp_dur_q;
    armed_d     = armed_q;

    if (note_field(32'(key_in)) == '0) begin
      armed_d = 1'b1;
    end

    case (state_q)
      IDLE, DONE: begin
        if (start_ok) begin
          state_d     = LEN;
          rom_song_d  = song_sel;
          rom_addr_d  = '0;
          note_idx_d  = '0;
          hit_count_d = '0;
          armed_d     = 1'b1;
        end
      end
      LEN:    state_d = LENCAP;
      LENCAP: begin
        len_d = rom_note[ADDR_W-1:0];
        if (rom_note[ADDR_W-1:0] == '0) begin
          state_d = DONE;
        end else begin
          note_idx_d = ADDR_W'(1);
          rom_addr_d = ADDR_W'(1);
          state_d    = FETCH;
        end
      end
      FETCH:  state_d = LOAD;
      LOAD: begin
        exp_note_d = rom_note;
        exp_dur_d  = rom_dur;
        state_d    = PLAY;
      end
      PLAY: begin
        if (hit) begin
          hit_count_d = hit_count_q + ADDR_W'(1);
          armed_d     = 1'b0;
          state_d     = ADV;
        end else if (timeout) begin
          state_d = ADV;
        end
      end
      ADV: begin
        if (note_idx_q == len_q) begin
          state_d = DONE;
        end else begin
          note_idx_d = note_idx_q + ADDR_W'(1);
          rom_addr_d = note_idx_q + ADDR_W'(1);
          state_d    = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next state so they line up with it.
    led_d = '0;
    if (state_d == PLAY) begin
      led_d = (state_q == LOAD) ? rom_note : exp_note_q;
    end
    busy_d = (state_d != IDLE) && (state_d != DONE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rom_song_q  <= '0;
      rom_addr_q  <= '0;
      len_q       <= '0;
      note_idx_q  <= '0;
      hit_count_q <= '0;
      exp_note_q  <= '0;
      exp_dur_q   <= '0;
      led_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      armed_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      rom_song_q  <= rom_song_d;
      rom_addr_q  <= rom_addr_d;
      len_q       <= len_d;
      note_idx_q  <= note_idx_d;
      hit_count_q <= hit_count_d;
      exp_note_q  <= exp_note_d;
      exp_dur_q   <= exp_dur_d;
      led_q       <= led_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      armed_q     <= armed_d;
    end
  end

  assign rom_song  = rom_song_q;
  assign rom_addr  = rom_addr_q;
  assign led       = led_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign note_idx  = note_idx_q;
  assign hit_count = hit_count_q;

endmodule

// File: tb/tb_learn_sequencer.sv
// Directed bench for learn_sequencer with a 1-cycle-latency song ROM model.
module tb_learn_sequencer;

  localparam logic [9:0] K1 = 10'h048;
  localparam logic [9:0] K2 = 10'h088;
  localparam logic [9:0] K3 = 10'h050;
  localparam logic [9:0] K4 = 10'h090;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [1:0] song_sel;
  logic       timed;
  logic [9:0] key_in;
  logic [1:0] rom_song;
  logic [6:0] rom_addr;
  logic [9:0] rom_note;
  logic [31:0] rom_dur;
  logic [9:0] led;
  logic       busy;
  logic       done;
  logic [6:0] note_idx;
  logic [6:0] hit_count;
  logic [6:0] miss_count;

  int checks;
  int failures;

  logic [9:0]  mem_note [4][128];
  logic [31:0] mem_dur  [4][128];

  learn_sequencer #(
    .NOTE_W (10),
    .ADDR_W (7),
    .DUR_W  (32),
    .SONG_W (2),
    .TIMEOUT(10)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .song_sel  (song_sel),
    .timed     (timed),
    .key_in    (key_in),
    .rom_song  (rom_song),
    .rom_addr  (rom_addr),
    .rom_note  (rom_note),
    .rom_dur   (rom_dur),
    .led       (led),
    .busy      (busy),
    .done      (done),
    .note_idx  (note_idx),
    .hit_count (hit_count),
    .miss_count(miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    rom_note <= mem_note[rom_song][rom_addr];
    rom_dur  <= mem_dur[rom_song][rom_addr];
  end

  typedef struct {
    logic       start;
    logic [9:0] key;
    logic [9:0] led;
    logic       busy;
    logic       done;
    logic [6:0] idx;
    logic [6:0] hits;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic st, input logic [9:0] key, input logic [9:0] l,
                     input logic b, input logic d, input logic [6:0] idx, input logic [6:0] h);
    vec_t v;
    v.start = st; v.key = key; v.led = l; v.busy = b; v.done = d; v.idx = idx; v.hits = h;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    start = 1'b0; key_in = '0; timed = 1'b0; song_sel = '0;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic start_song(input logic [1:0] sel, input logic t);
    song_sel = sel; timed = t; start = 1'b1;
    step(1);
    start = 1'b0; timed = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; failures = 0;
    for (int s = 0; s < 4; s++) begin
      for (int a = 0; a < 128; a++) begin
        mem_note[s][a] = '0;
        mem_dur[s][a]  = '0;
      end
    end
    mem_note[0][0] = 10'd2; mem_note[0][1] = K1; mem_note[0][2] = K2;
    mem_dur[0][1]  = 32'd3; mem_dur[0][2]  = 32'd3;
    mem_note[1][0] = 10'd0;
    mem_note[2][0] = 10'd2; mem_note[2][1] = K1; mem_note[2][2] = K1;
    mem_dur[2][1]  = 32'd3; mem_dur[2][2]  = 32'd3;
    mem_note[3][0] = 10'd2; mem_note[3][1] = K3; mem_note[3][2] = K4;
    mem_dur[3][1]  = 32'd9; mem_dur[3][2]  = 32'd3;

    // Song 0, wait mode: two clean 4-cycle presses, then a restart with a broken first press.
    add(1, 0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 1, 0, 1, 0);
    add(0, 0, 0, 1, 0, 1, 0);
    add(0, 0, K1, 1, 0, 1, 0);
    repeat (3) add(0, K1, K1, 1, 0, 1, 0);
    add(0, K1, 0, 1, 0, 1, 1);
    add(0, 0, 0, 1, 0, 2, 1);
    add(0, 0, 0, 1, 0, 2, 1);
    add(0, 0, K2, 1, 0, 2, 1);
    repeat (3) add(0, K2, K2, 1, 0, 2, 1);
    add(0, K2, 0, 1, 0, 2, 2);
    add(0, 0, 0, 0, 1, 2, 2);
    add(0, 0, 0, 0, 1, 2, 2);
    add(1, 0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 1, 0, 1, 0);
    add(0, 0, 0, 1, 0, 1, 0);
    add(0, 0, K1, 1, 0, 1, 0);
    repeat (3) add(0, K1, K1, 1, 0, 1, 0);
    add(0, 0, K1, 1, 0, 1, 0);
    repeat (3) add(0, K1, K1, 1, 0, 1, 0);
    add(0, K1, 0, 1, 0, 1, 1);
    add(0, 0, 0, 1, 0, 2, 1);

    rst_n = 1'b0; start = 1'b0; song_sel = '0; timed = 1'b0; key_in = '0;
    step(2);
    chk("rst_led", led, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_idx", note_idx, 0);
    chk("rst_hits", hit_count, 0);
    chk("rst_miss", miss_count, 0);
    chk("rst_addr", rom_addr, 0);
    chk("rst_song", rom_song, 0);
    rst_n = 1'b1;
    step(1);
    chk("idle_busy", busy, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      start = tbl[i].start; key_in = tbl[i].key; song_sel = '0; timed = 1'b0;
      step(1);
      chk($sformatf("tbl%0d_led", i), led, tbl[i].led);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].busy);
      chk($sformatf("tbl%0d_done", i), done, tbl[i].done);
      chk($sformatf("tbl%0d_idx", i), note_idx, tbl[i].idx);
      chk($sformatf("tbl%0d_hits", i), hit_count, tbl[i].hits);
    end
    start = 1'b0; key_in = '0;

    // Two identical notes: a continuous press must not score the second one.
    reset_dut();
    start_song(2'd2, 1'b0);
    step(4);
    chk("same_led1", led, K1);
    key_in = K1;
    step(3);
    chk("same_hold3", hit_count, 0);
    step(1);
    chk("same_hit1", hit_count, 1);
    step(3);
    chk("same_led2", led, K1);
    chk("same_idx2", note_idx, 2);
    song_sel = 2'd0; start = 1'b1;
    step(1);
    start = 1'b0;
    chk("busy_start_song", rom_song, 2);
    chk("busy_start_led", led, K1);
    step(7);
    chk("same_norescore", hit_count, 1);
    key_in = '0;
    step(1);
    key_in = K1;
    step(3);
    chk("same_rearm3", hit_count, 1);
    step(1);
    chk("same_hit2", hit_count, 2);
    key_in = '0;
    step(2);
    chk("same_done", done, 1);

    // Asynchronous reset mid-PLAY on note 2, then an empty song.
    reset_dut();
    start_song(2'd0, 1'b0);
    step(4);
    key_in = K1;
    step(4);
    key_in = '0;
    step(3);
    chk("mid_led2", led, K2);
    key_in = K2;
    step(2);
    rst_n = 1'b0;
    #1;
    chk("mid_busy", busy, 0);
    chk("mid_led", led, 0);
    chk("mid_hits", hit_count, 0);
    chk("mid_idx", note_idx, 0);
    chk("mid_addr", rom_addr, 0);
    rst_n = 1'b1;
    key_in = '0;
    step(1);
    start_song(2'd1, 1'b0);
    chk("empty_song", rom_song, 1);
    chk("empty_addr", rom_addr, 0);
    chk("empty_busy", busy, 1);
    step(2);
    chk("empty_done", done, 1);
    chk("empty_busy_end", busy, 0);
    chk("empty_idx", note_idx, 0);

`ifdef LEARN_TIMED_EN
    // Timed mode, no key: each note misses on its 10th PLAY cycle.
    reset_dut();
    start_song(2'd0, 1'b1);
    step(4);
    step(9);
    chk("tmo_wait9", miss_count, 0);
    chk("tmo_led1", led, K1);
    step(1);
    chk("tmo_miss1", miss_count, 1);
    chk("tmo_gap_led", led, 0);
    step(3);
    chk("tmo_led2", led, K2);
    step(9);
    chk("tmo_wait9b", miss_count, 1);
    step(1);
    chk("tmo_miss2", miss_count, 2);
    step(1);
    chk("tmo_done", done, 1);
    chk("tmo_hits", hit_count, 0);

    // Hit completing on the last window cycle beats the timeout.
    reset_dut();
    start_song(2'd3, 1'b1);
    step(4);
    chk("edge_led", led, K3);
    key_in = K3;
    step(9);
    chk("edge_pre_hits", hit_count, 0);
    step(1);
    chk("edge_hits", hit_count, 1);
    chk("edge_miss", miss_count, 0);
    key_in = '0;
    step(3);
    step(10);
    chk("edge_miss2", miss_count, 1);
    step(1);
    chk("edge_done", done, 1);
`else
    // Without timed support a timed start behaves as wait mode.
    reset_dut();
    start_song(2'd0, 1'b1);
    step(4);
    step(25);
    chk("notimed_led", led, K1);
    chk("notimed_busy", busy, 1);
    chk("notimed_miss", miss_count, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
